pipeline_control_irq_vector_fetch: RTL and testbench
====================================================

# pipeline_control_irq_vector_fetch

Parametrised interrupt-vector fetch unit in the pipeline control block. It converts an IRQ number into a handler address by reading an IDT entry through the shared load/store port. Each entry carries an attribute word and a handler word; a non-present entry is reported as a fault without fetching the handler. One further request can be queued while a fetch is in progress.

## Interface
Parameters:
- IRQ_NUM_W, 7: width of the IRQ number.
- ENTRY_SHIFT, 3: log2 of IDT entry size in bytes (minimum 3). Word 0 at +0 is the handler; word 1 at +4 is the attribute word.
- CHECK_ATTR, 1: 1 = fetch attribute word first and honour its present bit; 0 = handler-only fetch, attribute output forced to 32'h1.

Ports:
- iCLOCK  in  1  sole clock, rising edge.
- iRESET_SYNC  in  1  reset, synchronous, active-high.
- iSYSREG_IDTR  in  32  IDT base address; latched when a job launches.
- iIRQ_START  in  1  request strobe; accepted only when oIRQ_READY=1.
- iIRQ_NUM  in  IRQ_NUM_W  IRQ number qualified by iIRQ_START.
- oIRQ_READY  out  1  pending slot empty.
- oFINISH  out  1  one-cycle completion pulse.
- oFINISH_FAULT  out  1  entry not present; valid with oFINISH.
- oFINISH_HUNDLER  out  32  handler address; valid with oFINISH, 0 on fault.
- oFINISH_ATTR  out  32  attribute word; valid with oFINISH.
- oFINISH_NUM  out  IRQ_NUM_W  IRQ number of the completed job.
- oLDST_USE  out  1  port ownership; high in all states except IDLE.
- oLDST_REQ  out  1  access request.
- iLDST_BUSY  in  1  port stall; a request is accepted when oLDST_REQ=1 and iLDST_BUSY=0.
- oLDST_ORDER  out  2  fixed 2'b10 (word).
- oLDST_RW  out  1  fixed 0 (read).
- oLDST_ADDR  out  32  access address.
- oLDST_DATA  out  32  fixed 32'h0.
- iLDST_REQ  in  1  read data valid.
- iLDST_DATA  in  32  read data.

## Operation
- States: IDLE, REQ_ATTR, WAIT_ATTR, REQ_HND, WAIT_HND, DONE.
- Launch: in IDLE, a start (or a valid pending slot, which has priority) moves to REQ_ATTR when CHECK_ATTR=1, otherwise to REQ_HND. The launch latches the number and the IDTR value.
- Address: base = IDTR + (num << ENTRY_SHIFT), computed modulo 2^32 with no overflow flag. Attribute read uses base+4; handler read uses base.
- REQ_x: oLDST_REQ=1 with a stable address. It holds while iLDST_BUSY=1 and moves to WAIT_x on acceptance.
- WAIT_ATTR: on iLDST_REQ, latch the data. If bit0=0, set fault and go to DONE; otherwise go to REQ_HND.
- WAIT_HND: on iLDST_REQ, latch the handler and go to DONE.
- iLDST_REQ is ignored in the IDLE, REQ and DONE states.
- DONE: oFINISH=1 for exactly one cycle. The next state is REQ_x when the pending slot is valid or a start arrives in this cycle; otherwise IDLE.
- Pending slot (depth 1):
  - A start that is accepted while not idle, or while idle with the slot valid, is stored in the slot. The IDTR is not captured at this point.
  - The slot clears when its job launches.
  - A start with oIRQ_READY=0 is a protocol violation; it is dropped and the slot keeps its contents.
- Start in the same cycle the slot launches: the new start fills the slot, so no request is lost.

## Timing
- Reset values: state IDLE; slot empty; oIRQ_READY=1; oFINISH=0; oFINISH_FAULT=0; oFINISH_HUNDLER=0; oFINISH_ATTR=0; oFINISH_NUM=0; oLDST_USE=0; oLDST_REQ=0; oLDST_ADDR=0.
- All outputs are registered except the fixed constants.
- Zero-wait memory (busy low, data the cycle after acceptance), start sampled at edge 0:
  - REQ_ATTR in cycle 1, WAIT_ATTR in cycle 2, REQ_HND in cycle 3, WAIT_HND in cycle 4, oFINISH in cycle 5.
  - Fault path: oFINISH in cycle 3.
  - CHECK_ATTR=0: oFINISH in cycle 3.
- Each busy cycle adds one cycle of latency. Each wait cycle for data adds one cycle.
- Back-to-back jobs: the pending job's REQ state is the cycle after DONE, so there is no IDLE gap.
- Reset mid-operation: the next cycle is IDLE with the slot empty and oLDST_REQ/USE=0. No oFINISH is produced for the aborted job, and late iLDST_REQ is ignored.

## Test plan
- IDTR=32'h0000_1000, num=5, attribute 32'h1, handler 32'h0000_8000, zero wait:
  - Addresses 0x102C then 0x1028.
  - oFINISH at cycle 5 with HUNDLER=0x8000, FAULT=0, NUM=5.
- Same job with attribute 32'h0: a single access, oFINISH at cycle 3 with FAULT=1, HUNDLER=0.
- iLDST_BUSY held for 3 cycles during the handler request: address stable throughout, exactly one acceptance, oFINISH at cycle 8.
- Start num=1, then num=2 in cycle 2:
  - oIRQ_READY drops.
  - The second job's REQ_ATTR falls in the cycle after the first oFINISH.
  - Both results are correct in order.
- IDTR=32'hFFFF_FFF8, num=1, CHECK_ATTR=1: addresses wrap to 0x4 then 0x0.
- Assert iRESET_SYNC while in WAIT_HND, then drive iLDST_REQ the next cycle: no oFINISH, outputs at reset values, the next start completes normally.

Source files
------------

// File: rtl/pipeline_control_irq_vector_fetch_if.sv
// Bundle of the IRQ request/completion side and the shared load/store port
// used by the interrupt-vector fetch unit.
interface pipeline_control_irq_vector_fetch_if #(
   parameter int IRQ_NUM_W = 7
);
   logic [31:0]          iSYSREG_IDTR;
   logic                 iIRQ_START;
   logic [IRQ_NUM_W-1:0] iIRQ_NUM;
   logic                 oIRQ_READY;
   logic                 oFINISH;
   logic                 oFINISH_FAULT;
   logic [31:0]          oFINISH_HUNDLER;
   logic [31:0]          oFINISH_ATTR;
   logic [IRQ_NUM_W-1:0] oFINISH_NUM;
   logic                 oLDST_USE;
   logic                 oLDST_REQ;
   logic                 iLDST_BUSY;
   logic [1:0]           oLDST_ORDER;
   logic                 oLDST_RW;
   logic [31:0]          oLDST_ADDR;
   logic [31:0]          oLDST_DATA;
   logic                 iLDST_REQ;
   logic [31:0]          iLDST_DATA;

   modport master (
      output iSYSREG_IDTR, iIRQ_START, iIRQ_NUM,
      output iLDST_BUSY, iLDST_REQ, iLDST_DATA,
      input  oIRQ_READY, oFINISH, oFINISH_FAULT,
      input  oFINISH_HUNDLER, oFINISH_ATTR, oFINISH_NUM,
      input  oLDST_USE, oLDST_REQ, oLDST_ORDER,
      input  oLDST_RW, oLDST_ADDR, oLDST_DATA
   );

   modport slave (
      input  iSYSREG_IDTR, iIRQ_START, iIRQ_NUM,
      input  iLDST_BUSY, iLDST_REQ, iLDST_DATA,
      output oIRQ_READY, oFINISH, oFINISH_FAULT,
      output oFINISH_HUNDLER, oFINISH_ATTR, oFINISH_NUM,
      output oLDST_USE, oLDST_REQ, oLDST_ORDER,
      output oLDST_RW, oLDST_ADDR, oLDST_DATA
   );
endinterface

// File: rtl/pipeline_control_irq_vector_fetch.sv
// Interrupt-vector fetch: reads an IDT entry (attribute, then handler)
// over the shared load/store port, with a one-deep pending request slot.
module pipeline_control_irq_vector_fetch #(
   parameter int IRQ_NUM_W   = 7,
   parameter int ENTRY_SHIFT = 3,
   parameter bit CHECK_ATTR  = 1'b1
) (
   input logic iCLOCK,
   input logic iRESET_SYNC,
   pipeline_control_irq_vector_fetch_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, REQ_ATTR, WAIT_ATTR, REQ_HND, WAIT_HND, DONE
   } state_t;

   state_t state, state_n;

   logic                 slot_v, slot_v_n;
   logic [IRQ_NUM_W-1:0] slot_num, slot_num_n;
   logic [IRQ_NUM_W-1:0] num_q, num_n;
   logic [31:0]          base_q, base_n;
   logic [31:0]          attr_q, attr_n;

   logic                 ready_q, finish_q, fault_q, use_q, req_q;
   logic                 fault_n;
   logic [31:0]          hnd_q, hnd_n, fattr_q, fattr_n;
   logic [31:0]          addr_q, addr_n;
   logic [IRQ_NUM_W-1:0] fnum_q, fnum_n;

   logic                 start_acc, launch;
   logic [IRQ_NUM_W-1:0] launch_num;
   state_t               first_req;

   // ready_q mirrors an empty slot, so an accepted start never meets a full slot
   assign start_acc  = bus.iIRQ_START && ready_q;
   assign launch     = (state == IDLE || state == DONE)
                    && (slot_v || start_acc);
   assign launch_num = slot_v ? slot_num : bus.iIRQ_NUM;
   assign first_req  = CHECK_ATTR ? REQ_ATTR : REQ_HND;

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) state <= IDLE;
      else             state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:      if (launch) state_n = first_req;
         REQ_ATTR:  if (!bus.iLDST_BUSY) state_n = WAIT_ATTR;
         WAIT_ATTR: if (bus.iLDST_REQ)
                       state_n = bus.iLDST_DATA[0] ? REQ_HND : DONE;
         REQ_HND:   if (!bus.iLDST_BUSY) state_n = WAIT_HND;
         WAIT_HND:  if (bus.iLDST_REQ) state_n = DONE;
         DONE:      state_n = launch ? first_req : IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_comb begin
      slot_v_n   = slot_v;
      slot_num_n = slot_num;
      if (launch && slot_v) slot_v_n = 1'b0;
      if (start_acc && !launch) begin
         slot_v_n   = 1'b1;
         slot_num_n = bus.iIRQ_NUM;
      end

      num_n  = launch ? launch_num : num_q;
      base_n = launch
             ? bus.iSYSREG_IDTR + (32'(launch_num) << ENTRY_SHIFT)
             : base_q;

      attr_n = attr_q;
      if (state == WAIT_ATTR && bus.iLDST_REQ) attr_n = bus.iLDST_DATA;

      addr_n = addr_q;
      if (state_n == REQ_ATTR)     addr_n = base_n + 32'd4;
      else if (state_n == REQ_HND) addr_n = base_n;

      fault_n = fault_q;
      hnd_n   = hnd_q;
      fattr_n = fattr_q;
      fnum_n  = fnum_q;
      if (state_n == DONE) begin
         fnum_n = num_q;
         if (state == WAIT_ATTR) begin
            fault_n = 1'b1;
            hnd_n   = 32'h0;
            fattr_n = bus.iLDST_DATA;
         end else begin
            fault_n = 1'b0;
            hnd_n   = bus.iLDST_DATA;
            fattr_n = CHECK_ATTR ? attr_q : 32'h1;
         end
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         slot_v   <= 1'b0;
         slot_num <= '0;
         num_q    <= '0;
         base_q   <= 32'h0;
         attr_q   <= 32'h0;
         ready_q  <= 1'b1;
         finish_q <= 1'b0;
         fault_q  <= 1'b0;
         use_q    <= 1'b0;
         req_q    <= 1'b0;
         hnd_q    <= 32'h0;
         fattr_q  <= 32'h0;
         addr_q   <= 32'h0;
         fnum_q   <= '0;
      end else begin
         slot_v   <= slot_v_n;
         slot_num <= slot_num_n;
         num_q    <= num_n;
         base_q   <= base_n;
         attr_q   <= attr_n;
         ready_q  <= !slot_v_n;
         finish_q <= (state_n == DONE);
         fault_q  <= fault_n;
         use_q    <= (state_n != IDLE);
         req_q    <= (state_n == REQ_ATTR) || (state_n == REQ_HND);
         hnd_q    <= hnd_n;
         fattr_q  <= fattr_n;
         addr_q   <= addr_n;
         fnum_q   <= fnum_n;
      end
   end

   assign bus.oIRQ_READY      = ready_q;
   assign bus.oFINISH         = finish_q;
   assign bus.oFINISH_FAULT   = fault_q;
   assign bus.oFINISH_HUNDLER = hnd_q;
   assign bus.oFINISH_ATTR    = fattr_q;
   assign bus.oFINISH_NUM     = fnum_q;
   assign bus.oLDST_USE       = use_q;
   assign bus.oLDST_REQ       = req_q;
   assign bus.oLDST_ORDER     = 2'b10;
   assign bus.oLDST_RW        = 1'b0;
   assign bus.oLDST_ADDR      = addr_q;
   assign bus.oLDST_DATA      = 32'h0;

endmodule

// File: tb/tb_pipeline_control_irq_vector_fetch.sv
// Bench for the IRQ vector fetch unit: memory responder, completion
// monitor and a table-level model of what each IRQ job must return.
module tb_pipeline_control_irq_vector_fetch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipeline_control_irq_vector_fetch_if #(.IRQ_NUM_W(7)) bus ();

   pipeline_control_irq_vector_fetch #(
      .IRQ_NUM_W(7), .ENTRY_SHIFT(3), .CHECK_ATTR(1'b1)
   ) dut (
      .iCLOCK(clk),
      .iRESET_SYNC(rst),
      .bus(bus)
   );

   typedef struct {
      int          cyc;
      logic        fault;
      logic [31:0] hnd;
      logic [31:0] attr;
      logic [6:0]  num;
   } res_t;

   typedef struct {
      int          cyc;
      logic [31:0] addr;
   } acc_t;

   logic [31:0] mem [logic [31:0]];
   res_t        fin_q[$];
   acc_t        acc_q[$];
   int unsigned busy_q[$];
   int unsigned lat_q[$];
   int unsigned max_busy = 0;
   int unsigned max_lat = 0;

   bit          in_req = 0;
   bit          armed = 0;
   bit          addr_bad = 0;
   int unsigned busy_left = 0;
   int unsigned lat_left = 0;
   logic [31:0] req_addr = 0;
   logic [31:0] rsp_addr = 0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
   endfunction

   // What an IDT lookup must yield, straight from the entry layout
   function automatic res_t model(input logic [31:0] idtr,
                                  input logic [6:0] n);
      res_t        r;
      logic [31:0] base;
      base   = idtr + 32'(n) * 32'd8;
      r.cyc  = 0;
      r.num  = n;
      r.attr = mem_rd(base + 32'd4);
      r.fault = !r.attr[0];
      r.hnd  = r.fault ? 32'h0 : mem_rd(base);
      return r;
   endfunction

   always @(negedge clk) begin
      bus.iLDST_REQ  = 1'b0;
      bus.iLDST_BUSY = 1'b0;
      if (armed) begin
         if (lat_left == 0) begin
            bus.iLDST_REQ  = 1'b1;
            bus.iLDST_DATA = mem_rd(rsp_addr);
            armed = 0;
         end else begin
            lat_left--;
         end
      end
      if (rst) begin
         in_req = 0;
      end else if (bus.oLDST_REQ) begin
         if (!in_req) begin
            in_req   = 1;
            req_addr = bus.oLDST_ADDR;
            if (busy_q.size() > 0) busy_left = busy_q.pop_front();
            else busy_left = $urandom_range(max_busy, 0);
         end else if (bus.oLDST_ADDR !== req_addr) begin
            addr_bad = 1;
         end
         if (busy_left > 0) begin
            bus.iLDST_BUSY = 1'b1;
            busy_left--;
         end else begin
            acc_t a;
            in_req   = 0;
            armed    = 1;
            rsp_addr = bus.oLDST_ADDR;
            if (lat_q.size() > 0) lat_left = lat_q.pop_front();
            else lat_left = $urandom_range(max_lat, 0);
            a.cyc  = cyc;
            a.addr = rsp_addr;
            acc_q.push_back(a);
         end
      end
   end

   always @(negedge clk) begin
      if (bus.oFINISH) begin
         res_t r;
         r.cyc   = cyc;
         r.fault = bus.oFINISH_FAULT;
         r.hnd   = bus.oFINISH_HUNDLER;
         r.attr  = bus.oFINISH_ATTR;
         r.num   = bus.oFINISH_NUM;
         fin_q.push_back(r);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      fin_q.delete();
      acc_q.delete();
      busy_q.delete();
      lat_q.delete();
      addr_bad = 0;
      max_busy = 0;
      max_lat  = 0;
   endtask

   task automatic do_start(input logic [6:0] n, output int s);
      @(negedge clk);
      bus.iIRQ_START = 1'b1;
      bus.iIRQ_NUM   = n;
      s = cyc;
      @(negedge clk);
      bus.iIRQ_START = 1'b0;
   endtask

   task automatic wait_fin(input int n, input int budget, output bit ok);
      int k = 0;
      while (fin_q.size() < n && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      ok = (fin_q.size() >= n);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks += 6;
      if (bus.oIRQ_READY !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b exp 1", bus.oIRQ_READY);
      end
      if (bus.oFINISH !== 1'b0 || bus.oFINISH_FAULT !== 1'b0) begin
         errors++; $display("FAIL reset_finish got %b/%b exp 0/0",
                            bus.oFINISH, bus.oFINISH_FAULT);
      end
      if (bus.oLDST_USE !== 1'b0 || bus.oLDST_REQ !== 1'b0) begin
         errors++; $display("FAIL reset_ldst got %b/%b exp 0/0",
                            bus.oLDST_USE, bus.oLDST_REQ);
      end
      if (bus.oLDST_ADDR !== 32'h0) begin
         errors++; $display("FAIL reset_addr got %h exp 0", bus.oLDST_ADDR);
      end
      if (bus.oFINISH_HUNDLER !== 32'h0 || bus.oFINISH_ATTR !== 32'h0) begin
         errors++; $display("FAIL reset_result got %h/%h exp 0/0",
                            bus.oFINISH_HUNDLER, bus.oFINISH_ATTR);
      end
      if (bus.oFINISH_NUM !== 7'h0) begin
         errors++; $display("FAIL reset_num got %h exp 0", bus.oFINISH_NUM);
      end
   endtask

   task automatic test_basic(input logic [31:0] attr, input int exp_cyc,
                             input int exp_acc);
      int   s;
      bit   ok;
      res_t e;
      clear_logs();
      bus.iSYSREG_IDTR = 32'h0000_1000;
      mem[32'h102C] = attr;
      mem[32'h1028] = 32'h0000_8000;
      e = model(32'h0000_1000, 7'd5);
      do_start(7'd5, s);
      wait_fin(1, 30, ok);
      idle(3);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL basic_timeout got 0 finishes exp 1");
      end else begin
         checks += 3;
         if (fin_q[0].cyc - s !== exp_cyc) begin
            errors++; $display("FAIL basic_latency got %0d exp %0d",
                               fin_q[0].cyc - s, exp_cyc);
         end
         if (fin_q[0].fault !== e.fault || fin_q[0].hnd !== e.hnd ||
             fin_q[0].attr !== e.attr) begin
            errors++; $display("FAIL basic_result got %b %h %h exp %b %h %h",
               fin_q[0].fault, fin_q[0].hnd, fin_q[0].attr,
               e.fault, e.hnd, e.attr);
         end
         if (fin_q[0].num !== 7'd5) begin
            errors++; $display("FAIL basic_num got %0d exp 5", fin_q[0].num);
         end
      end
      checks++;
      if (acc_q.size() !== exp_acc) begin
         errors++; $display("FAIL basic_acc_count got %0d exp %0d",
                            acc_q.size(), exp_acc);
      end else begin
         checks += 2;
         if (acc_q[0].addr !== 32'h102C || acc_q[0].cyc - s !== 1) begin
            errors++; $display("FAIL basic_attr_addr got %h@%0d exp 102c@1",
                               acc_q[0].addr, acc_q[0].cyc - s);
         end
         if (exp_acc == 2 &&
             (acc_q[1].addr !== 32'h1028 || acc_q[1].cyc - s !== 3)) begin
            errors++; $display("FAIL basic_hnd_addr got %h@%0d exp 1028@3",
                               acc_q[1].addr, acc_q[1].cyc - s);
         end
      end
   endtask

   task automatic test_busy();
      int s;
      bit ok;
      clear_logs();
      bus.iSYSREG_IDTR = 32'h0000_1000;
      mem[32'h102C] = 32'h1;
      mem[32'h1028] = 32'h0000_8000;
      busy_q.push_back(0);
      busy_q.push_back(3);
      do_start(7'd5, s);
      wait_fin(1, 30, ok);
      idle(3);
      checks += 3;
      if (!ok || fin_q[0].cyc - s !== 8 || fin_q[0].hnd !== 32'h8000) begin
         errors++; $display("FAIL busy_finish got ok=%b exp finish at 8", ok);
      end
      if (acc_q.size() !== 2) begin
         errors++; $display("FAIL busy_acc_count got %0d exp 2", acc_q.size());
      end
      if (addr_bad !== 1'b0) begin
         errors++; $display("FAIL busy_addr_stable got %b exp 0", addr_bad);
      end
   endtask

   task automatic test_back_to_back();
      int   s;
      bit   ok;
      res_t e1;
      res_t e2;
      clear_logs();
      bus.iSYSREG_IDTR = 32'h0000_1000;
      mem[32'h100C] = 32'h3;
      mem[32'h1008] = 32'h0001_1110;
      mem[32'h2014] = 32'h5;
      mem[32'h2010] = 32'h0002_2220;
      e1 = model(32'h0000_1000, 7'd1);
      e2 = model(32'h0000_2000, 7'd2);
      do_start(7'd1, s);
      @(negedge clk);
      bus.iIRQ_START = 1'b1;
      bus.iIRQ_NUM   = 7'd2;
      @(negedge clk);
      bus.iIRQ_START = 1'b0;
      bus.iSYSREG_IDTR = 32'h0000_2000;
      checks++;
      if (bus.oIRQ_READY !== 1'b0) begin
         errors++; $display("FAIL b2b_ready_drop got %b exp 0", bus.oIRQ_READY);
      end
      while (cyc < s + 6) @(negedge clk);
      checks++;
      if (bus.oIRQ_READY !== 1'b1) begin
         errors++; $display("FAIL b2b_ready_back got %b exp 1", bus.oIRQ_READY);
      end
      wait_fin(2, 40, ok);
      idle(3);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL b2b_timeout got %0d exp 2", fin_q.size());
      end else begin
         checks += 4;
         if (fin_q[0].cyc - s !== 5) begin
            errors++; $display("FAIL b2b_first_latency got %0d exp 5",
                               fin_q[0].cyc - s);
         end
         if (acc_q.size() !== 4 || acc_q[2].cyc !== fin_q[0].cyc + 1 ||
             acc_q[2].addr !== 32'h2014) begin
            errors++; $display("FAIL b2b_second_req got n=%0d exp 4 accesses",
                               acc_q.size());
         end
         if (fin_q[0].num !== e1.num || fin_q[0].hnd !== e1.hnd ||
             fin_q[0].fault !== e1.fault) begin
            errors++; $display("FAIL b2b_job1 got %0d %h exp %0d %h",
               fin_q[0].num, fin_q[0].hnd, e1.num, e1.hnd);
         end
         if (fin_q[1].num !== e2.num || fin_q[1].hnd !== e2.hnd ||
             fin_q[1].fault !== e2.fault) begin
            errors++; $display("FAIL b2b_job2 got %0d %h exp %0d %h",
               fin_q[1].num, fin_q[1].hnd, e2.num, e2.hnd);
         end
      end
   endtask

   task automatic test_wrap();
      int s;
      bit ok;
      clear_logs();
      bus.iSYSREG_IDTR = 32'hFFFF_FFF8;
      mem[32'h4] = 32'h1;
      mem[32'h0] = 32'hABCD_0000;
      do_start(7'd1, s);
      wait_fin(1, 30, ok);
      idle(3);
      checks += 2;
      if (acc_q.size() !== 2 || acc_q[0].addr !== 32'h4 ||
          acc_q[1].addr !== 32'h0) begin
         errors++; $display("FAIL wrap_addr got n=%0d exp 4 then 0",
                            acc_q.size());
      end
      if (!ok || fin_q[0].hnd !== 32'hABCD_0000) begin
         errors++; $display("FAIL wrap_result got ok=%b exp abcd0000", ok);
      end
   endtask

   task automatic test_reset_mid();
      int   s;
      bit   ok;
      res_t e;
      clear_logs();
      bus.iSYSREG_IDTR = 32'h0000_3000;
      mem[32'h3034] = 32'h1;
      mem[32'h3030] = 32'h0000_7770;
      lat_q.push_back(0);
      lat_q.push_back(1);
      do_start(7'd6, s);
      while (cyc < s + 4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks += 3;
      if (bus.oLDST_USE !== 1'b0 || bus.oLDST_REQ !== 1'b0) begin
         errors++; $display("FAIL rstmid_ldst got %b/%b exp 0/0",
                            bus.oLDST_USE, bus.oLDST_REQ);
      end
      if (bus.oIRQ_READY !== 1'b1 || bus.oLDST_ADDR !== 32'h0) begin
         errors++; $display("FAIL rstmid_state got %b %h exp 1 0",
                            bus.oIRQ_READY, bus.oLDST_ADDR);
      end
      if (bus.oFINISH !== 1'b0 || bus.oFINISH_HUNDLER !== 32'h0) begin
         errors++; $display("FAIL rstmid_finish got %b %h exp 0 0",
                            bus.oFINISH, bus.oFINISH_HUNDLER);
      end
      idle(6);
      checks++;
      if (fin_q.size() !== 0) begin
         errors++; $display("FAIL rstmid_no_finish got %0d exp 0",
                            fin_q.size());
      end
      e = model(32'h0000_3000, 7'd6);
      do_start(7'd6, s);
      wait_fin(1, 30, ok);
      checks++;
      if (!ok || fin_q[0].cyc - s !== 5 || fin_q[0].hnd !== e.hnd) begin
         errors++; $display("FAIL rstmid_restart got ok=%b exp %h at 5",
                            ok, e.hnd);
      end
   endtask

   task automatic test_random();
      res_t       exp_q[$];
      int         sent = 0;
      int         budget = 0;
      logic [6:0] n;
      clear_logs();
      max_busy = 2;
      max_lat  = 2;
      bus.iSYSREG_IDTR = $urandom;
      while ((sent < 40 || fin_q.size() < exp_q.size()) && budget < 4000) begin
         @(negedge clk);
         budget++;
         bus.iIRQ_START = 1'b0;
         if (sent < 40) begin
            if (bus.oIRQ_READY && $urandom_range(2, 0) == 0) begin
               n = 7'($urandom);
               bus.iIRQ_START = 1'b1;
               bus.iIRQ_NUM   = n;
               exp_q.push_back(model(bus.iSYSREG_IDTR, n));
               sent++;
            end else if (!bus.oIRQ_READY && $urandom_range(7, 0) == 0) begin
               bus.iIRQ_START = 1'b1;
               bus.iIRQ_NUM   = 7'($urandom);
            end
         end
      end
      bus.iIRQ_START = 1'b0;
      idle(12);
      checks++;
      if (fin_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL rand_count got %0d exp %0d",
                            fin_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (fin_q[i].num !== exp_q[i].num ||
                fin_q[i].fault !== exp_q[i].fault ||
                fin_q[i].hnd !== exp_q[i].hnd ||
                fin_q[i].attr !== exp_q[i].attr) begin
               errors++;
               $display("FAIL rand_job%0d got %0d %b %h %h exp %0d %b %h %h",
                  i, fin_q[i].num, fin_q[i].fault, fin_q[i].hnd,
                  fin_q[i].attr, exp_q[i].num, exp_q[i].fault,
                  exp_q[i].hnd, exp_q[i].attr);
            end
         end
      end
   endtask

   initial begin
      bus.iSYSREG_IDTR = 32'h0;
      bus.iIRQ_START   = 1'b0;
      bus.iIRQ_NUM     = 7'h0;
      bus.iLDST_BUSY   = 1'b0;
      bus.iLDST_REQ    = 1'b0;
      bus.iLDST_DATA   = 32'h0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_basic(32'h1, 5, 2);
      test_basic(32'h0, 3, 1);
      test_busy();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
